// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module   : clk_div_pkg
// Brief    : Shared types and helpers for the multi-channel clock divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } cfg_state_t;

  localparam int DIV_WIDTH_DEFAULT = 8;

  // Number of source cycles the divided clock spends high within one period.
  function automatic int unsigned half_period(input int unsigned n);
    return n >> 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_channel.sv
// ============================================================================
// Module   : clk_div_channel
// Brief    : One divided-clock channel: enable sync, counter, divisor, output.
//            Optional CLK_DIV_ODD_DUTY_EN adds a negedge flop for 50% odd duty.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT,
  parameter int DIV_INIT  = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 en_async_i,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] load_div_i,
  output logic                 clk_o,
  output logic                 boundary_o
);

  logic [1:0]           en_sync;
  logic [DIV_WIDTH-1:0] div;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] next_div;
  logic [DIV_WIDTH-1:0] half;
  logic                 running;
  logic                 clk_q;
  logic                 off_now;
  logic                 at_end;
  logic                 next_on;

  // Loads are only issued on a boundary, so next_div equals div everywhere else.
  assign next_div   = load_i ? load_div_i : div;
  assign next_on    = (next_div >= DIV_WIDTH'(2));
  assign half       = DIV_WIDTH'(half_period(32'(next_div)));
  assign off_now    = (div < DIV_WIDTH'(2));
  assign at_end     = running && (cnt == div - DIV_WIDTH'(1));
  assign boundary_o = off_now || !running || at_end;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en_sync <= 2'b00;
      div     <= DIV_WIDTH'(DIV_INIT);
      cnt     <= '0;
      running <= 1'b0;
      clk_q   <= 1'b0;
    end else begin
      en_sync <= {en_sync[0], en_async_i};
      div     <= next_div;
      if (boundary_o) begin
        cnt <= '0;
        if (next_on && en_sync[1]) begin
          running <= 1'b1;
          clk_q   <= 1'b1;
        end else begin
          running <= 1'b0;
          clk_q   <= 1'b0;
        end
      end else begin
        cnt   <= cnt + DIV_WIDTH'(1);
        clk_q <= (cnt + DIV_WIDTH'(1)) < half;
      end
    end
  end

`ifdef CLK_DIV_ODD_DUTY_EN
  logic neg_q;

  // Stretches the high phase by half a source cycle; only applied for odd N.
  always_ff @(negedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= clk_q;
    end
  end

  assign clk_o = clk_q | (div[0] & neg_q);
`else
  assign clk_o = clk_q;
`endif

endmodule

`default_nettype wire

// File: rtl/clk_div_multi.sv
// ============================================================================
// Module   : clk_div_multi
// Brief    : NUM_CH-output clock divider with boundary-aligned divisor updates.
//            Optional feature macro: CLK_DIV_ODD_DUTY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH    = 2,
  parameter  int DIV_WIDTH = DIV_WIDTH_DEFAULT,
  parameter  int DIV_INIT  = 2,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CH_W-1:0]      cfg_ch_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  output logic                 cfg_done_o,
  input  logic [NUM_CH-1:0]    en_async_i,
  output logic [NUM_CH-1:0]    clk_o
);

  cfg_state_t           state;
  logic [CH_W-1:0]      cap_ch;
  logic [DIV_WIDTH-1:0] cap_div;
  logic [NUM_CH-1:0]    boundary;
  logic [NUM_CH-1:0]    load;
  logic                 sel_boundary;

  // An out-of-range channel has no boundary to wait for, so it completes at once.
  always_comb begin
    sel_boundary = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cap_ch == CH_W'(c)) sel_boundary = boundary[c];
    end
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign load[c] = (state == WAIT) && (cap_ch == CH_W'(c)) && boundary[c];

      clk_div_channel #(
        .DIV_WIDTH (DIV_WIDTH),
        .DIV_INIT  (DIV_INIT)
      ) u_channel (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .en_async_i (en_async_i[c]),
        .load_i     (load[c]),
        .load_div_i (cap_div),
        .clk_o      (clk_o[c]),
        .boundary_o (boundary[c])
      );
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      cfg_ready_o <= 1'b1;
      cfg_done_o  <= 1'b0;
      cap_ch      <= '0;
      cap_div     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cfg_done_o <= 1'b0;
          if (cfg_valid_i && cfg_ready_o) begin
            cap_ch      <= cfg_ch_i;
            cap_div     <= cfg_div_i;
            cfg_ready_o <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (sel_boundary) begin
            cfg_done_o <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          cfg_done_o  <= 1'b0;
          cfg_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          cfg_done_o  <= 1'b0;
          cfg_ready_o <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
